// File: rtl/hc8_carry_chain.sv
// hc8_carry_chain
// Byte-serial multi-precision carry resolver. It sits after the 8-bit
// Han-Carlson adder stage. That adder has no carry-in, so this block adds
// the carry from the previous byte of a frame (LSB byte first) into each sum
// byte. Resolved bytes go through a small output FIFO with valid/ready.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : adder beat valid
//   in_ready   : block can accept a beat (depends on FIFO occupancy only)
//   in_sum     : adder sum byte
//   in_cout    : adder carry-out
//   in_first   : beat is the LSB byte of a frame
//   in_last    : beat is the MSB byte of a frame
//   out_valid  : FIFO head valid
//   out_ready  : downstream accepts the head
//   out_data   : resolved byte
//   out_last   : head is the final byte of its frame
//   out_carry  : final carry of the frame (0 unless out_last)
//   frame_err  : one-cycle pulse after a framing violation
//   byte_cnt   : bytes accepted in the current frame
//
// state | meaning
// IDLE  | between frames; the next beat starts a frame with cin=0
// BUSY  | inside a frame; the carry register feeds the next beat
module hc8_carry_chain #(
    parameter int W          = 8,
    parameter int MAX_BYTES  = 16,
    parameter int FIFO_DEPTH = 2,
    localparam int CW        = $clog2(MAX_BYTES) + 1,
    localparam int PW        = $clog2(FIFO_DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_sum,
    input  logic          in_cout,
    input  logic          in_first,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_last,
    output logic          out_carry,
    output logic          frame_err,
    output logic [CW-1:0] byte_cnt
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state;
    logic           c;

    logic [W+1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW:0]    count;

    logic           accept;
    logic           pop;
    logic           start;
    logic           cin;
    logic [W-1:0]   data_res;
    logic           c_next;
    logic [CW-1:0]  cnt_next;
    logic           hit_max;
    logic           last_eff;
    logic           err;
    logic [W+1:0]   head;

    assign in_ready  = (count != (PW+1)'(FIFO_DEPTH));
    assign out_valid = (count != '0);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // A first-flagged beat always restarts, even mid-frame.
    assign start    = in_first | (state == IDLE);
    assign cin      = start ? 1'b0 : c;
    assign data_res = in_sum + W'(cin);
    // The carry-in ripples out only through an all-ones sum byte. The adder
    // never produces cout=1 together with an all-ones sum, so OR is exact.
    assign c_next   = in_cout | (cin & (&in_sum));
    assign cnt_next = start ? CW'(1) : byte_cnt + CW'(1);
    assign hit_max  = (cnt_next == CW'(MAX_BYTES));
    assign last_eff = in_last | hit_max;
    assign err      = ((state == IDLE) & ~in_first)
                    | ((state == BUSY) &  in_first)
                    | (hit_max & ~in_last);

    // Outputs are forced to zero while the FIFO is empty, so a drained FIFO
    // shows no stale data.
    assign head      = mem[rd_ptr];
    assign out_data  = out_valid ? head[W+1:2] : '0;
    assign out_last  = out_valid & head[1];
    assign out_carry = out_valid & head[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            c         <= 1'b0;
            byte_cnt  <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= accept & err;
            if (accept) begin
                c        <= c_next;
                state    <= last_eff ? IDLE : BUSY;
                byte_cnt <= last_eff ? '0 : cnt_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (accept) begin
                mem[wr_ptr] <= {data_res, last_eff, last_eff & c_next};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({accept, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_hc8_carry_chain.sv
module tb_hc8_carry_chain;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_sum;
    logic       in_cout;
    logic       in_first;
    logic       in_last;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_carry;
    logic       frame_err;
    logic [4:0] byte_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int err_cnt  = 0;
    bit rnd_mode = 1'b0;
    bit ready_fix = 1'b1;

    // entry = {data, last, carry}
    logic [9:0] exp_q[$];
    logic [9:0] obs_q[$];

    hc8_carry_chain #(.W(8), .MAX_BYTES(16), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
        .in_cout(in_cout), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_carry(out_carry),
        .frame_err(frame_err), .byte_cnt(byte_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        out_ready = rnd_mode ? 1'($urandom % 2) : ready_fix;
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid && out_ready)
            obs_q.push_back({out_data, out_last, out_carry});
        if (rst_n === 1'b1 && frame_err)
            err_cnt++;
    end

    task automatic send_beat(input logic [7:0] s, input logic co,
                             input logic f, input logic l);
        int n;
        in_valid = 1'b1; in_sum = s; in_cout = co; in_first = f; in_last = l;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                $display("FAIL send_beat_timeout: in_ready stayed %b, expected 1", in_ready);
                n_fail++;
                $fatal(1, "in_ready never asserted");
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (obs_q.size() >= n && !out_valid) begin ok = 1'b1; break; end
        end
    endtask

    task automatic flush_start();
        bit ok;
        rnd_mode = 1'b0; ready_fix = 1'b1;
        wait_drain(0, ok);
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_sum = '0; in_cout = 1'b0;
        in_first = 1'b0; in_last = 1'b0;
        #22 rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if ({out_data, out_last, out_carry} !== 10'h0) begin n_fail++; $display("FAIL reset_out_fields: got %h expected 000", {out_data, out_last, out_carry}); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        n_checks++; if (byte_cnt !== 5'd0) begin n_fail++; $display("FAIL reset_byte_cnt: got %0d expected 0", byte_cnt); end
    endtask

    task automatic test_vectors();
        bit ok;
        int e0;
        flush_start();
        e0 = err_cnt;
        // 0x80+0x80 single beat
        send_beat(8'h00, 1'b1, 1'b1, 1'b1);
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL vec_single_err: got %b expected 0", frame_err); end
        exp_q.push_back({8'h00, 1'b1, 1'b1});
        // 0x01FF+0x0001
        send_beat(8'h00, 1'b1, 1'b1, 1'b0);
        n_checks++; if (byte_cnt !== 5'd1) begin n_fail++; $display("FAIL vec_cnt_first: got %0d expected 1", byte_cnt); end
        send_beat(8'h01, 1'b0, 1'b0, 1'b1);
        n_checks++; if (byte_cnt !== 5'd0) begin n_fail++; $display("FAIL vec_cnt_last: got %0d expected 0", byte_cnt); end
        exp_q.push_back({8'h00, 1'b0, 1'b0});
        exp_q.push_back({8'h02, 1'b1, 1'b0});
        // 0xFFFF+0x0001
        send_beat(8'h00, 1'b1, 1'b1, 1'b0);
        send_beat(8'hFF, 1'b0, 1'b0, 1'b1);
        exp_q.push_back({8'h00, 1'b0, 1'b0});
        exp_q.push_back({8'h00, 1'b1, 1'b1});
        wait_drain(exp_q.size(), ok);
        n_checks++; if (!ok || obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL vec_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL vec_out[%0d]: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 10'hx, exp_q[i]); end
        end
        n_checks++; if (err_cnt != e0) begin n_fail++; $display("FAIL vec_no_err: got %0d pulses expected 0", err_cnt - e0); end
    endtask

    task automatic test_random_frames();
        bit ok;
        int e0, nf;
        logic [63:0] a, b, m;
        logic [71:0] s;
        logic [8:0]  bs;
        int len;
        flush_start();
        e0 = err_cnt;
        rnd_mode = 1'b1;
        for (int f = 0; f < 25; f++) begin
            len = $urandom_range(1, 8);
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            m = (len == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * len)) - 64'd1);
            a &= m; b &= m;
            s = {8'h00, a} + {8'h00, b};
            for (int i = 0; i < len; i++) begin
                bs = {1'b0, a[8*i +: 8]} + {1'b0, b[8*i +: 8]};
                send_beat(bs[7:0], bs[8], i == 0, i == len - 1);
                exp_q.push_back({s[8*i +: 8], i == len - 1, (i == len - 1) ? s[8*len] : 1'b0});
                if ($urandom % 4 == 0) begin @(posedge clk); #1; end
            end
        end
        wait_drain(exp_q.size(), ok);
        nf = 0;
        n_checks++; if (!ok || obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_fail++; nf++;
                if (nf < 10) $display("FAIL rnd_out[%0d]: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 10'hx, exp_q[i]);
            end
        end
        n_checks++; if (err_cnt != e0) begin n_fail++; $display("FAIL rnd_no_err: got %0d pulses expected 0", err_cnt - e0); end
        rnd_mode = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int k;
        logic [7:0] sums [4];
        logic [7:0] head0;
        flush_start();
        sums[0] = 8'h11; sums[1] = 8'h22; sums[2] = 8'h33; sums[3] = 8'h44;
        ready_fix = 1'b0;
        repeat (2) @(posedge clk); #1;
        k = 0;
        in_valid = 1'b1; in_cout = 1'b0;
        in_sum = sums[0]; in_first = 1'b1; in_last = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            if (in_ready) k++;
            @(posedge clk); #1;
            if (k < 4) begin in_sum = sums[k]; in_first = (k == 0); in_last = (k == 3); end
            if (cyc == 0) head0 = out_data;
            else begin
                n_checks++; if (out_data !== head0 || out_data !== 8'h11) begin n_fail++; $display("FAIL bp_head_stable: got %h expected 11", out_data); end
            end
        end
        in_valid = 1'b0;
        n_checks++; if (k != 2) begin n_fail++; $display("FAIL bp_accepted: got %0d expected 2", k); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
        ready_fix = 1'b1;
        send_beat(sums[2], 1'b0, 1'b0, 1'b0);
        send_beat(sums[3], 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) exp_q.push_back({sums[i], i == 3, 1'b0});
        wait_drain(4, ok);
        n_checks++; if (!ok || obs_q.size() != 4) begin n_fail++; $display("FAIL bp_count: got %0d expected 4", obs_q.size()); end
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_out[%0d]: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 10'hx, exp_q[i]); end
        end
    endtask

    task automatic test_framing();
        bit ok;
        int e0;
        flush_start();
        // leave carry register at 1, then a first=0 beat in IDLE
        send_beat(8'h00, 1'b1, 1'b1, 1'b1);
        exp_q.push_back({8'h00, 1'b1, 1'b1});
        e0 = err_cnt;
        send_beat(8'h10, 1'b0, 1'b0, 1'b1);
        n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL fr_idle_pulse: got %b expected 1", frame_err); end
        exp_q.push_back({8'h10, 1'b1, 1'b0});
        @(posedge clk); #1;
        n_checks++; if (err_cnt != e0 + 1) begin n_fail++; $display("FAIL fr_idle_count: got %0d expected 1", err_cnt - e0); end
        // restart while busy
        send_beat(8'h00, 1'b1, 1'b1, 1'b0);
        exp_q.push_back({8'h00, 1'b0, 1'b0});
        send_beat(8'h05, 1'b0, 1'b1, 1'b1);
        exp_q.push_back({8'h05, 1'b1, 1'b0});
        @(posedge clk); #1;
        n_checks++; if (err_cnt != e0 + 2) begin n_fail++; $display("FAIL fr_busy_count: got %0d expected 2", err_cnt - e0); end
        // 16 beats without in_last: 0x00 cout=1 then fifteen 0xFF
        send_beat(8'h00, 1'b1, 1'b1, 1'b0);
        exp_q.push_back({8'h00, 1'b0, 1'b0});
        for (int i = 2; i <= 16; i++) begin
            send_beat(8'hFF, 1'b0, 1'b0, 1'b0);
            exp_q.push_back({8'h00, i == 16, i == 16});
            if (i == 15) begin
                n_checks++; if (byte_cnt !== 5'd15) begin n_fail++; $display("FAIL fr_cnt15: got %0d expected 15", byte_cnt); end
            end
        end
        n_checks++; if (byte_cnt !== 5'd0) begin n_fail++; $display("FAIL fr_cnt_wrap: got %0d expected 0", byte_cnt); end
        n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL fr_max_pulse: got %b expected 1", frame_err); end
        @(posedge clk); #1;
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL fr_pulse_width: got %b expected 0", frame_err); end
        n_checks++; if (err_cnt != e0 + 3) begin n_fail++; $display("FAIL fr_total_count: got %0d expected 3", err_cnt - e0); end
        wait_drain(exp_q.size(), ok);
        n_checks++; if (!ok || obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL fr_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL fr_out[%0d]: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 10'hx, exp_q[i]); end
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int e0;
        flush_start();
        ready_fix = 1'b0;
        repeat (2) @(posedge clk); #1;
        send_beat(8'h00, 1'b1, 1'b1, 1'b0);
        send_beat(8'hFF, 1'b0, 1'b0, 1'b0);
        n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL rm_full: got valid=%b ready=%b expected 1 0", out_valid, in_ready); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rm_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (byte_cnt !== 5'd0) begin n_fail++; $display("FAIL rm_byte_cnt: got %0d expected 0", byte_cnt); end
        #3 rst_n = 1'b1;
        exp_q.delete(); obs_q.delete();
        ready_fix = 1'b1;
        repeat (2) @(posedge clk); #1;
        e0 = err_cnt;
        send_beat(8'h07, 1'b0, 1'b0, 1'b1);
        exp_q.push_back({8'h07, 1'b1, 1'b0});
        wait_drain(1, ok);
        n_checks++; if (!ok || obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL rm_after: got %h (n=%0d) expected %h", (obs_q.size() > 0) ? obs_q[0] : 10'hx, obs_q.size(), exp_q[0]); end
        n_checks++; if (err_cnt != e0 + 1) begin n_fail++; $display("FAIL rm_err: got %0d expected 1", err_cnt - e0); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random_frames();
        test_back_to_back();
        test_framing();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
